sram_arbiter: RTL and testbench

- Shares one sram_controller port among NUM_REQ requesters, e.g. the message loader, the SHA-256 round engine and the digest readout.
- Grants one request per cycle, using round-robin or fixed priority.
- Drives the sram_controller request inputs from registers.
- Tracks outstanding reads in an in-order tag FIFO and routes each returned dat_ready/data to the requester that issued the read.

---
 rtl/sram_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one sram_controller port among NUM_REQ requesters.
// - One grant per cycle, round-robin by default. Defining the macro
//   SRAM_ARB_FIXED_PRIO_EN switches to strict fixed priority (requester 0
//   highest) and removes the round-robin pointer.
// - The memctrl_* request fields are driven from registers.
// - Outstanding reads are tracked in an in-order tag FIFO. Each returned
//   dat_ready/data is routed to the requester that issued that read.
//
// Handshake: requester i hands over a request on a rising edge where
// req_valid[i] & req_ready[i] is high. req_ready is combinational and is
// either one-hot or all zero. A requester must hold its fields stable while
// req_valid is high and it has not yet been accepted.

module sram_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          memctrl_enable,
    output logic                          memctrl_rw,
    output logic [ADDR_WIDTH-1:0]         memctrl_addr,
    output logic [DATA_WIDTH-1:0]         memctrl_write_data,
    input  logic                          dat_ready,
    input  logic [DATA_WIDTH-1:0]         memctrl_out_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_REQ-1:0]    eligible;
    logic                  fifo_full;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      cand;
    logic                  found;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  win_rw;

    logic [IDX_W-1:0]      tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    // A read is held off whenever the FIFO is full, even if a pop is happening
    // in the same cycle. This keeps the full/grant path free of dat_ready.
    assign fifo_full = (count == CNT_W'(MAX_OUTSTANDING));
    assign eligible  = req_valid & (~req_rw | {NUM_REQ{~fifo_full}});

`ifdef SRAM_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-numbered eligible requester wins.
    always_comb begin
        req_ready = '0;
        win_idx   = '0;
        cand      = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'(i);
            if (!found && eligible[cand]) begin
                req_ready[cand] = 1'b1;
                win_idx         = cand;
                found           = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] last_gnt;

    // Round-robin: search from the requester after the last winner, wrapping.
    always_comb begin
        req_ready = '0;
        win_idx   = '0;
        cand      = '0;
        found     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                req_ready[cand] = 1'b1;
                win_idx         = cand;
                found           = 1'b1;
            end
        end
    end

    // Move the round-robin pointer only when a grant is actually taken. The
    // reset value makes requester 0 the first in line.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_gnt <= IDX_W'(NUM_REQ - 1);
        end else if (accept) begin
            last_gnt <= win_idx;
        end
    end
`endif

    // req_ready is only ever set for an eligible (hence valid) requester.
    assign accept    = |req_ready;
    assign win_rw    = req_rw[win_idx];
    assign win_addr  = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_wdata = req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign push      = accept & win_rw;
    assign pop       = dat_ready & (count != '0);

    // Register the winning request toward the controller. Fields hold when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            memctrl_enable     <= 1'b0;
            memctrl_rw         <= 1'b0;
            memctrl_addr       <= '0;
            memctrl_write_data <= '0;
        end else begin
            memctrl_enable <= accept;
            if (accept) begin
                memctrl_rw         <= win_rw;
                memctrl_addr       <= win_addr;
                memctrl_write_data <= win_wdata;
            end
        end
    end

    // Tag storage: needs no reset because the pointers and count decide
    // which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem[wr_ptr] <= win_idx;
        end
    end

    // Tag FIFO pointers and occupancy. A push and a pop in the same cycle leave
    // count unchanged. Both pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Route read data to the owner of the head tag. A dat_ready that arrives
    // with no read outstanding is flagged and stays flagged until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (pop) begin
                rsp_valid <= NUM_REQ'(1) << tag_mem[rd_ptr];
                rsp_data  <= memctrl_out_data;
            end else begin
                rsp_valid <= '0;
            end
            if (dat_ready && (count == '0)) begin
                rsp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter with two requesters. A small SRAM model
// returns read data one cycle after memctrl_enable. Scenarios can instead
// drive dat_ready/data by hand through man_ready/man_data.

module tb_sram_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 3;
    localparam int DW      = 32;
    localparam int MAXO    = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_rw = '0;
    logic [NUM_REQ*AW-1:0] req_addr = '0;
    logic [NUM_REQ*DW-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic                 rsp_err;
    logic                 memctrl_enable;
    logic                 memctrl_rw;
    logic [AW-1:0]        memctrl_addr;
    logic [DW-1:0]        memctrl_write_data;
    logic                 dat_ready;
    logic [DW-1:0]        memctrl_out_data;

    logic                 model_en = 1'b1;
    logic                 man_ready = 1'b0;
    logic [DW-1:0]        man_data = '0;
    logic                 mdl_ready;
    logic [DW-1:0]        mdl_data;
    logic [DW-1:0]        mem [8] = '{32'h0, 32'h1111_0001, 32'h2222_0002, 32'hDEAD_BEEF,
                                      32'h0, 32'h0, 32'h0, 32'h0};

    int checks = 0;
    int errors = 0;

    sram_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .memctrl_enable(memctrl_enable), .memctrl_rw(memctrl_rw), .memctrl_addr(memctrl_addr),
        .memctrl_write_data(memctrl_write_data),
        .dat_ready(dat_ready), .memctrl_out_data(memctrl_out_data)
    );

    // Clock / reset block
    always #5 clock = ~clock;

    assign dat_ready        = model_en ? mdl_ready : man_ready;
    assign memctrl_out_data = model_en ? mdl_data  : man_data;

    // SRAM controller stand-in: one-cycle enable-to-dat_ready, shares reset.
    always @(posedge clock) begin
        if (reset) begin
            mdl_ready <= 1'b0;
            mdl_data  <= '0;
        end else begin
            mdl_ready <= memctrl_enable & memctrl_rw;
            if (memctrl_enable & memctrl_rw) mdl_data <= mem[memctrl_addr];
            if (memctrl_enable & ~memctrl_rw) mem[memctrl_addr] <= memctrl_write_data;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        man_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({memctrl_enable, memctrl_rw, memctrl_addr, memctrl_write_data} !== '0) begin
            errors++;
            $display("FAIL reset_memctrl: got en=%b rw=%b addr=%h wd=%h, expected all 0",
                     memctrl_enable, memctrl_rw, memctrl_addr, memctrl_write_data);
        end
        checks++;
        if ({rsp_valid, rsp_data, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%b data=%h err=%b, expected all 0",
                     rsp_valid, rsp_data, rsp_err);
        end
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle_ready: got %b expected 00", req_ready);
        end
        req_valid = 2'b11;
        req_rw    = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: got %b expected 01", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single_read();
        model_en  = 1'b1;
        req_rw    = 2'b01;
        req_addr  = {3'd0, 3'd3};
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got %b expected 01", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if ({memctrl_enable, memctrl_rw, memctrl_addr} !== {1'b1, 1'b1, 3'd3}) begin
            errors++;
            $display("FAIL single_issue: got en=%b rw=%b addr=%h expected en=1 rw=1 addr=3",
                     memctrl_enable, memctrl_rw, memctrl_addr);
        end
        tick();
        checks++;
        if ({memctrl_enable, rsp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL single_mid: got en=%b rsp_valid=%b expected en=0 rsp_valid=00",
                     memctrl_enable, rsp_valid);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_err} !== {2'b01, 32'hDEAD_BEEF, 1'b0}) begin
            errors++;
            $display("FAIL single_rsp: got valid=%b data=%h err=%b expected 01 deadbeef 0",
                     rsp_valid, rsp_data, rsp_err);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data} !== {2'b00, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL single_rsp_after: got valid=%b data=%h expected 00 deadbeef",
                     rsp_valid, rsp_data);
        end
    endtask

    task automatic test_contention();
        logic [DW+NUM_REQ-1:0] exp_q[$];
        logic [DW+NUM_REQ-1:0] head;
        logic [1:0]            exp_gnt;
        int                    nrsp;
        do_reset();
        model_en = 1'b1;
        nrsp     = 0;
        req_addr = {3'd2, 3'd1};
        req_rw   = 2'b11;
        for (int k = 0; k < 10; k++) begin
            if (k < 6) begin
                req_valid = 2'b11;
`ifdef SRAM_ARB_FIXED_PRIO_EN
                exp_gnt = 2'b01;
`else
                exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
                #1;
                checks++;
                if (req_ready !== exp_gnt) begin
                    errors++;
                    $display("FAIL contention_grant[%0d]: got %b expected %b", k, req_ready, exp_gnt);
                end
                exp_q.push_back({exp_gnt, (exp_gnt == 2'b01) ? 32'h1111_0001 : 32'h2222_0002});
            end else begin
                req_valid = '0;
            end
            tick();
            checks++;
            if (memctrl_enable !== (k < 6)) begin
                errors++;
                $display("FAIL contention_enable[%0d]: got %b expected %b", k, memctrl_enable, (k < 6));
            end
            if (rsp_valid !== 2'b00) begin
                nrsp++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL contention_extra_rsp: got valid=%b expected none", rsp_valid);
                end else begin
                    head = exp_q.pop_front();
                    if ({rsp_valid, rsp_data} !== head) begin
                        errors++;
                        $display("FAIL contention_rsp: got %b/%h expected %b/%h",
                                 rsp_valid, rsp_data, head[DW+:NUM_REQ], head[DW-1:0]);
                    end
                end
            end
        end
        checks++;
        if (nrsp !== 6) begin
            errors++;
            $display("FAIL contention_rsp_count: got %0d expected 6", nrsp);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        model_en  = 1'b0;
        man_ready = 1'b0;
        req_addr  = {3'd4, 3'd6};
        req_wdata = {32'h0, 32'h0BAD_F00D};
        req_rw    = 2'b10;
        req_valid = 2'b10;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req_ready !== 2'b10) begin
                errors++;
                $display("FAIL full_read_accept[%0d]: got %b expected 10", k, req_ready);
            end
            tick();
        end
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL full_fifth_blocked: got %b expected 00", req_ready);
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL full_write_passes: got %b expected 01", req_ready);
        end
        tick();
        req_valid = 2'b10;
        man_ready = 1'b1;
        man_data  = 32'hA5A5_0001;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL full_blocked_on_pop: got %b expected 00", req_ready);
        end
        tick();
        man_ready = 1'b0;
        checks++;
        if ({rsp_valid, rsp_data} !== {2'b10, 32'hA5A5_0001}) begin
            errors++;
            $display("FAIL full_pop_rsp: got %b/%h expected 10/a5a50001", rsp_valid, rsp_data);
        end
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL full_after_pop: got %b expected 10", req_ready);
        end
        tick();
        req_valid = '0;
        for (int j = 0; j < 4; j++) begin
            man_ready = 1'b1;
            man_data  = 32'hC0DE_0000 + j;
            tick();
            man_ready = 1'b0;
            checks++;
            if ({rsp_valid, rsp_data} !== {2'b10, 32'hC0DE_0000 + j}) begin
                errors++;
                $display("FAIL full_drain[%0d]: got %b/%h expected 10/%h",
                         j, rsp_valid, rsp_data, 32'hC0DE_0000 + j);
            end
        end
        checks++;
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL full_no_err: got %b expected 0", rsp_err);
        end
    endtask

    task automatic test_mixed();
        do_reset();
        model_en  = 1'b1;
        req_rw    = 2'b00;
        req_addr  = {3'd0, 3'd5};
        req_wdata = {32'h0, 32'h1234_5678};
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL mixed_write_ready: got %b expected 01", req_ready);
        end
        tick();
        checks++;
        if ({memctrl_enable, memctrl_rw, memctrl_addr, memctrl_write_data} !==
            {1'b1, 1'b0, 3'd5, 32'h1234_5678}) begin
            errors++;
            $display("FAIL mixed_write_issue: got en=%b rw=%b addr=%h wd=%h expected 1 0 5 12345678",
                     memctrl_enable, memctrl_rw, memctrl_addr, memctrl_write_data);
        end
        req_rw    = 2'b10;
        req_addr  = {3'd5, 3'd0};
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL mixed_read_ready: got %b expected 10", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if ({memctrl_enable, memctrl_rw, memctrl_addr} !== {1'b1, 1'b1, 3'd5}) begin
            errors++;
            $display("FAIL mixed_read_issue: got en=%b rw=%b addr=%h expected 1 1 5",
                     memctrl_enable, memctrl_rw, memctrl_addr);
        end
        tick();
        tick();
        checks++;
        if ({rsp_valid, rsp_data} !== {2'b10, 32'h1234_5678}) begin
            errors++;
            $display("FAIL mixed_rsp: got %b/%h expected 10/12345678", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_error();
        do_reset();
        model_en  = 1'b0;
        man_ready = 1'b1;
        man_data  = 32'hFFFF_FFFF;
        tick();
        man_ready = 1'b0;
        checks++;
        if ({rsp_err, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL error_set: got err=%b valid=%b expected err=1 valid=00", rsp_err, rsp_valid);
        end
        tick();
        tick();
        checks++;
        if ({rsp_err, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL error_sticky: got err=%b valid=%b expected err=1 valid=00", rsp_err, rsp_valid);
        end
        do_reset();
        checks++;
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL error_cleared: got %b expected 0", rsp_err);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        model_en  = 1'b0;
        man_ready = 1'b0;
        req_rw    = 2'b01;
        req_addr  = {3'd0, 3'd7};
        req_wdata = {32'h0, 32'h5555_AAAA};
        req_valid = 2'b01;
        tick();
        tick();
        tick();
        req_valid = '0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({memctrl_enable, memctrl_rw, memctrl_addr, memctrl_write_data,
             rsp_valid, rsp_data, rsp_err} !== '0) begin
            errors++;
            $display("FAIL midflight_outputs: got en=%b rw=%b addr=%h valid=%b data=%h err=%b expected all 0",
                     memctrl_enable, memctrl_rw, memctrl_addr, rsp_valid, rsp_data, rsp_err);
        end
        // With the FIFO emptied by reset, a dat_ready must look like a stray one.
        man_ready = 1'b1;
        man_data  = 32'h7777_7777;
        tick();
        man_ready = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err} !== 3'b001) begin
            errors++;
            $display("FAIL midflight_tags_dropped: got valid=%b err=%b expected valid=00 err=1",
                     rsp_valid, rsp_err);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (rsp_valid !== 2'b00) begin
                errors++;
                $display("FAIL midflight_no_rsp[%0d]: got %b expected 00", k, rsp_valid);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_fifo_full();
        test_mixed();
        test_error();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
